// File: rtl/window_pkg.sv
// Shared types for the window assembler.
//   sample_t    : one signed sample at the default width.
//   win_state_e : assembler FSM states.
package window_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Filling the register, holding a presented window, or collecting stride samples.
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_STRIDE = 2'd2
  } win_state_e;
endpackage

// File: rtl/window_shift_reg.sv
// Sample storage for the window assembler. Each shift moves every tap one
// slot toward index 0 and loads din into the newest slot.
//   clk, rst_n : clock, async active-low reset (clears all taps)
//   shift_en   : shift one sample in this cycle
//   din        : incoming sample
//   taps       : [0] = oldest ... [WINDOW_SIZE-1] = newest
module window_shift_reg #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         shift_en,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] taps [0:WINDOW_SIZE-1]
);
  logic signed [DATA_WIDTH-1:0] taps_q [0:WINDOW_SIZE-1];
  logic signed [DATA_WIDTH-1:0] taps_d [0:WINDOW_SIZE-1];

  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      for (int i = 0; i < WINDOW_SIZE-1; i++) taps_d[i] = taps_q[i+1];
      taps_d[WINDOW_SIZE-1] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WINDOW_SIZE; i++) taps_q[i] <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;
endmodule

// File: rtl/window_assembler.sv
// Scalar sample stream -> parallel sliding window.
// Samples shift into a WINDOW_SIZE-deep register; the window is presented
// once full and again after every STRIDE further samples.
//   clk, rst_n   : clock, async active-low reset
//   flush        : sync clear of fill/stride state, overrides both handshakes
//   s_data/s_valid/s_ready       : input sample stream
//   win_out/win_valid/win_ready  : window output, [0] oldest
//   fill_count   : samples held, saturating at WINDOW_SIZE
module window_assembler
  import window_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 32,
  parameter int STRIDE      = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic signed [DATA_WIDTH-1:0]         s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic signed [DATA_WIDTH-1:0]         win_out [0:WINDOW_SIZE-1],
  output logic                                 win_valid,
  input  logic                                 win_ready,
  output logic [$clog2(WINDOW_SIZE+1)-1:0]     fill_count
);
  localparam int FW = $clog2(WINDOW_SIZE+1);
  localparam int SW = $clog2(STRIDE+1);
  localparam logic [FW-1:0] FILL_LAST   = FW'(WINDOW_SIZE-1);
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE-1);

  generate
    if (WINDOW_SIZE < 2) begin : g_bad_ws
      $error("window_assembler: WINDOW_SIZE must be >= 2");
    end
    if (STRIDE < 1 || STRIDE > WINDOW_SIZE) begin : g_bad_stride
      $error("window_assembler: STRIDE must be in 1..WINDOW_SIZE");
    end
  endgenerate

  win_state_e      state_q, state_d;
  logic [FW-1:0]   fill_count_q, fill_count_d;
  logic [SW-1:0]   stride_cnt_q, stride_cnt_d;
  logic            shift_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      fill_count_q <= '0;
      stride_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_count_q <= fill_count_d;
      stride_cnt_q <= stride_cnt_d;
    end
  end

  // Next state. s_ready is 1 in FILL/STRIDE, so s_valid alone means accept
  // there. fill_count cannot move in STRIDE: it is already saturated.
  always_comb begin
    state_d      = state_q;
    fill_count_d = fill_count_q;
    stride_cnt_d = stride_cnt_q;
    if (flush) begin
      state_d      = ST_FILL;
      fill_count_d = '0;
      stride_cnt_d = '0;
    end else begin
      case (state_q)
        ST_FILL: if (s_valid) begin
          fill_count_d = fill_count_q + 1'b1;
          if (fill_count_q == FILL_LAST) state_d = ST_HOLD;
        end
        ST_HOLD: if (win_ready) begin
          state_d      = ST_STRIDE;
          stride_cnt_d = '0;
        end
        ST_STRIDE: if (s_valid) begin
          stride_cnt_d = stride_cnt_q + 1'b1;
          if (stride_cnt_q == STRIDE_LAST) state_d = ST_HOLD;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // Outputs decode from state only, so win_ready never reaches s_ready.
  always_comb begin
    s_ready   = (state_q != ST_HOLD);
    win_valid = (state_q == ST_HOLD);
    shift_en  = s_valid && s_ready && !flush;
  end

  assign fill_count = fill_count_q;

  window_shift_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (s_data),
    .taps     (win_out)
  );
endmodule

// File: tb/tb_window_assembler.sv
module tb_window_assembler;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int SA = 2;
  localparam int SB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: STRIDE=2
  logic                 flush = 0, s_valid = 0, win_ready = 0;
  logic signed [DW-1:0] s_data = '0;
  logic                 s_ready, win_valid;
  logic signed [DW-1:0] win_out [0:W-1];
  logic [2:0]           fill_count;

  // DUT B: STRIDE=4
  logic                 s_valid_b = 0, win_ready_b = 0;
  logic signed [DW-1:0] s_data_b = '0;
  logic                 s_ready_b, win_valid_b;
  logic signed [DW-1:0] win_out_b [0:W-1];
  logic [2:0]           fill_count_b;

  window_assembler #(.DATA_WIDTH(DW), .WINDOW_SIZE(W), .STRIDE(SA)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready),
    .fill_count(fill_count));

  window_assembler #(.DATA_WIDTH(DW), .WINDOW_SIZE(W), .STRIDE(SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .win_out(win_out_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
    .fill_count(fill_count_b));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model for DUT A: total samples accepted since the last
  // flush/reset, whether a window is waiting, and the last W samples.
  int                   cnt = 0;
  bit                   pend = 0;
  logic signed [DW-1:0] sh [0:W-1];

  task automatic model_reset();
    cnt = 0; pend = 0;
    for (int i = 0; i < W; i++) sh[i] = '0;
  endtask

  task automatic check_a(input string tag);
    chk({tag, "_s_ready"}, s_ready, !pend);
    chk({tag, "_win_valid"}, win_valid, pend);
    chk({tag, "_fill"}, fill_count, (cnt < W) ? cnt : W);
    for (int i = 0; i < W; i++) chk($sformatf("%s_win%0d", tag, i), win_out[i], sh[i]);
  endtask

  // One clock of DUT A: drive, clock, advance the model, check.
  task automatic step_a(input string tag, input bit sv, input int sd,
                        input bit wr, input bit fl);
    s_valid = sv; s_data = DW'(sd); win_ready = wr; flush = fl;
    @(posedge clk);
    if (fl) begin
      cnt = 0; pend = 0;
    end else if (pend) begin
      if (wr) pend = 0;
    end else if (sv) begin
      for (int i = 0; i < W-1; i++) sh[i] = sh[i+1];
      sh[W-1] = DW'(sd);
      cnt++;
      // Window due once full, then every SA samples after that.
      if (cnt >= W && (cnt - W) % SA == 0) pend = 1;
    end
    #1;
    check_a(tag);
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c, input int d);
    int e [0:W-1];
    e = '{a, b, c, d};
    for (int i = 0; i < W; i++) chk($sformatf("%s%0d", tag, i), win_out[i], e[i]);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fill", fill_count, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: first window
    for (int v = 1; v <= 4; v++) step_a("t1", 1, v, 1, 0);
    chk("t1_valid", win_valid, 1);
    chk("t1_s_ready", s_ready, 0);
    chk_win("t1_w", 1, 2, 3, 4);

    // 2: stride of 2 -> {3,4,5,6}; then a single sample gives no window
    step_a("t2c", 1, 5, 1, 0);            // window consumed, sample refused
    step_a("t2", 1, 5, 0, 0);
    step_a("t2", 1, 6, 0, 0);
    chk("t2_valid", win_valid, 1);
    chk_win("t2_w", 3, 4, 5, 6);
    step_a("t2c", 0, 0, 1, 0);
    step_a("t2", 1, 7, 1, 0);
    for (int k = 0; k < 3; k++) step_a("t2i", 0, 0, 1, 0);
    chk("t2_novalid", win_valid, 0);
    chk("t2_fill", fill_count, 4);

    // 3: backpressure on window
    step_a("t3", 1, 8, 0, 0);
    for (int k = 0; k < 10; k++) step_a("t3h", 1, 100 + k, 0, 0);
    chk_win("t3_w", 5, 6, 7, 8);
    step_a("t3r", 1, 200, 1, 0);
    step_a("t3n", 1, 201, 0, 0);
    chk("t3_next", win_out[W-1], 201);

    // 4: flush after 3 samples, refill
    step_a("t4f", 0, 0, 0, 1);
    for (int v = 1; v <= 3; v++) step_a("t4p", 1, 50 + v, 0, 0);
    step_a("t4f", 1, 99, 1, 1);
    chk("t4_fill0", fill_count, 0);
    for (int v = 10; v <= 13; v++) begin
      step_a("t4", 1, v, 0, 0);
      chk($sformatf("t4_fill_%0d", v), fill_count, v - 9);
    end
    chk_win("t4_w", 10, 11, 12, 13);

    // 5: async reset while holding a window
    step_a("t5", 0, 0, 0, 0);
    chk("t5_pre", win_valid, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    chk("t5_valid", win_valid, 0);
    chk("t5_fill", fill_count, 0);
    for (int i = 0; i < W; i++) chk($sformatf("t5_win%0d", i), win_out[i], 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    check_a("t5post");

    // Random traffic on DUT A against the model
    for (int k = 0; k < 400; k++)
      step_a("rnd", ($urandom % 4) != 0, int'($urandom) - 32'sh8000_0000,
             $urandom % 2, ($urandom % 25) == 0);
    step_a("rndf", 0, 0, 0, 1);

    // 6: STRIDE=4 on DUT B, non-overlapping windows under random win_ready
    begin
      int idx, nwin, cyc;
      int capt [0:3][0:W-1];
      bit acc, wacc;
      idx = 0; nwin = 0; cyc = 0;
      while (!(idx == 16 && nwin >= 4) && cyc < 2000) begin
        s_valid_b   = (idx < 16) && ($urandom % 3 != 0);
        s_data_b    = DW'(idx - 8);
        win_ready_b = $urandom % 2;
        #1;
        acc  = s_valid_b && s_ready_b;
        wacc = win_valid_b && win_ready_b;
        if (wacc) begin
          if (nwin < 4) for (int j = 0; j < W; j++) capt[nwin][j] = win_out_b[j];
          nwin++;
        end
        @(posedge clk);
        if (acc) idx++;
        #1;
        cyc++;
      end
      s_valid_b = 0; win_ready_b = 1;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (win_valid_b) nwin++;
      end
      chk("t6_samples", idx, 16);
      chk("t6_nwin", nwin, 4);
      for (int w = 0; w < 4; w++)
        for (int j = 0; j < W; j++)
          chk($sformatf("t6_w%0d_%0d", w, j), (w < nwin) ? capt[w][j] : 9999, -8 + 4*w + j);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
